// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data access: size codes, FSM states,
// and the lane helpers used to build byte enables and replicated store data.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // The reserved code 11 behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == 2'b11) ? SZ_WORD : sz;
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] be;
      case (sz)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] w);
      logic [31:0] r;
      case (sz)
         SZ_BYTE: r = {4{w[7:0]}};
         SZ_HALF: r = {2{w[15:0]}};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Word-wide memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_load_align.sv
// Combinational little-endian lane extraction and sign/zero extension of load data.
module load_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         SZ_BYTE: data = {{24{~uns & byte_sel[7]}}, byte_sel};
         SZ_HALF: data = {{16{~uns & half_sel[15]}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store engine: IDLE -> BUSY (hold bus until ack) -> DONE, stalling the pipe meanwhile.
// Build option MEM_MISALIGN_EXC_EN: misaligned accesses skip the bus and pulse misalign instead.
module mem_access
   import mips_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_ex_mm,
   input  logic        MemWrite_ex_mm,
   input  logic [31:0] y_ex_mm,
   input  logic [31:0] wdata_ex_mm,
   input  logic [1:0]  size_ex_mm,
   input  logic        Unsigned_ex_mm,
   output logic [31:0] data,
   output logic        stall,
`ifdef MEM_MISALIGN_EXC_EN
   output logic        misalign,
`endif
   mem_access_if.master bus
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] data_q, data_d;
   logic        misalign_q, misalign_d;
   logic [31:0] ld_data;
   logic [1:0]  sz_in;

   load_align u_load_align (
      .rdata   (bus.mem_rdata),
      .addr_lo (addr_q[1:0]),
      .size    (size_q),
      .uns     (uns_q),
      .data    (ld_data)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      uns_d      = uns_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      data_d     = data_q;
      misalign_d = 1'b0;
      stall      = 1'b0;
      sz_in      = norm_size(size_ex_mm);

      case (state_q)
         ST_IDLE: begin
            if (MemRead_ex_mm || MemWrite_ex_mm) begin
               stall   = 1'b1;
               addr_d  = y_ex_mm;
               size_d  = sz_in;
               uns_d   = Unsigned_ex_mm;
               we_d    = MemWrite_ex_mm;
               wdata_d = lane_wdata(sz_in, wdata_ex_mm);
               be_d    = lane_be(sz_in, y_ex_mm[1:0]);
               state_d = ST_BUSY;
`ifdef MEM_MISALIGN_EXC_EN
               if (is_misaligned(sz_in, y_ex_mm[1:0])) begin
                  misalign_d = 1'b1;
                  state_d    = ST_DONE;
               end
`endif
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (bus.mem_ack) begin
               state_d = ST_DONE;
               if (!we_q) data_d = ld_data;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         data_q     <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         data_q     <= data_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.mem_req   = (state_q == ST_BUSY);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;
   assign data          = data_q;
`ifdef MEM_MISALIGN_EXC_EN
   assign misalign      = misalign_q;
`else
   logic unused_misalign;
   assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized accesses vs a lane model.
module tb_mem_access;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead_ex_mm, MemWrite_ex_mm, Unsigned_ex_mm;
   logic [31:0] y_ex_mm, wdata_ex_mm;
   logic [1:0]  size_ex_mm;
   logic [31:0] data;
   logic        stall;
`ifdef MEM_MISALIGN_EXC_EN
   logic        misalign;
`endif
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_data;

   mem_access_if bus ();

   mem_access dut (
      .clk            (clk),
      .reset          (reset),
      .MemRead_ex_mm  (MemRead_ex_mm),
      .MemWrite_ex_mm (MemWrite_ex_mm),
      .y_ex_mm        (y_ex_mm),
      .wdata_ex_mm    (wdata_ex_mm),
      .size_ex_mm     (size_ex_mm),
      .Unsigned_ex_mm (Unsigned_ex_mm),
      .data           (data),
      .stall          (stall),
`ifdef MEM_MISALIGN_EXC_EN
      .misalign       (misalign),
`endif
      .bus            (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          stall_cyc;
      int          busy_cyc;
      int          mis_cyc;
      logic        first_stall;
      logic        stable;
      logic        done;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
      logic [3:0]  be;
      logic        we;
   } obs_t;

   // ---------------- reference model (byte-count arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic int lane_off(input logic [31:0] a, input logic [1:0] sz);
      int a4 = int'(a[1:0]);
      return a4 - (a4 % nbytes(sz));
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
      int m = ((1 << nbytes(sz)) - 1) << lane_off(a, sz);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
      logic [31:0] r;
      int nb = nbytes(sz);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                              input logic [1:0] sz, input logic uns);
      int nb = nbytes(sz);
      logic [31:0] v = rd >> (8 * lane_off(a, sz));
      logic [31:0] mask;
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         v = v & mask;
         if (!uns && v[8*nb-1]) v = v | ~mask;
      end
      return v;
   endfunction

   function automatic logic model_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_MISALIGN_EXC_EN
      return (int'(a[1:0]) % nbytes(sz)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // ---------------- stimulus driver and memory responder ----------------
   // Called just after a rising edge; returns just after the edge that ends DONE,
   // leaving the request inputs asserted so a following call runs back to back.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                             input int delay, input logic [31:0] rdat, output obs_t o);
      o.stall_cyc = 0; o.busy_cyc = 0; o.mis_cyc = 0;
      o.first_stall = 1'b0; o.stable = 1'b1; o.done = 1'b0;
      o.addr = '0; o.wdata = '0; o.data = '0; o.be = '0; o.we = 1'b0;
      MemRead_ex_mm = rd; MemWrite_ex_mm = wr; y_ex_mm = a; wdata_ex_mm = wd;
      size_ex_mm = sz; Unsigned_ex_mm = uns;
      bus.mem_ack = 1'b0; bus.mem_rdata = rdat;
      for (int cyc = 0; cyc < 64 && !o.done; cyc++) begin
         @(negedge clk);
         if (cyc == 0) o.first_stall = stall;
         if (stall) o.stall_cyc++;
`ifdef MEM_MISALIGN_EXC_EN
         if (misalign) o.mis_cyc++;
`endif
         if (bus.mem_req) begin
            o.busy_cyc++;
            if (o.busy_cyc == 1) begin
               o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
               o.be = bus.mem_be; o.we = bus.mem_we;
            end else if (bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata ||
                         bus.mem_be !== o.be || bus.mem_we !== o.we) begin
               o.stable = 1'b0;
            end
            bus.mem_ack = (o.busy_cyc - 1 >= delay);
         end else begin
            // Junk acks outside BUSY must be ignored.
            bus.mem_ack = 1'($urandom_range(0, 1));
            if (!stall && o.stall_cyc > 0) begin
               o.done = 1'b1;
               o.data = data;
            end
         end
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic go_idle(input int n);
      MemRead_ex_mm = 1'b0; MemWrite_ex_mm = 1'b0; bus.mem_ack = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      MemRead_ex_mm = 1'b0; MemWrite_ex_mm = 1'b0; y_ex_mm = '0; wdata_ex_mm = '0;
      size_ex_mm = SZ_WORD; Unsigned_ex_mm = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
      checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++;
         $display("FAIL reset_req_we got %b%b want 00", bus.mem_req, bus.mem_we); end
      checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin errors++;
         $display("FAIL reset_bus got addr %h wdata %h be %b want all 0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
`ifdef MEM_MISALIGN_EXC_EN
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
`endif
      @(posedge clk); #1;
      ref_data = 32'h0;
   endtask

   task automatic test_word_load();
      obs_t o;
      run_access(1'b1, 1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, 0, 32'hDEADBEEF, o);
      go_idle(1);
      checks++; if (!o.done) begin errors++; $display("FAIL word_load_timeout got no DONE want DONE"); end
      checks++; if (o.stall_cyc != 2) begin errors++; $display("FAIL word_load_stall got %0d want 2", o.stall_cyc); end
      checks++; if (o.be !== 4'b1111 || o.addr !== 32'h100 || o.we !== 1'b0) begin errors++;
         $display("FAIL word_load_bus got be %b addr %h we %b want 1111 100 0", o.be, o.addr, o.we); end
      checks++; if (o.data !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data got %h want deadbeef", o.data); end
      ref_data = 32'hDEADBEEF;
   endtask

   task automatic test_byte_load();
      obs_t o;
      run_access(1'b1, 1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b0, 0, 32'h80000000, o);
      go_idle(1);
      checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL byte_load_be got %b want 1000", o.be); end
      checks++; if (o.data !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed got %h want ffffff80", o.data); end
      run_access(1'b1, 1'b0, 32'h103, 32'h0, SZ_BYTE, 1'b1, 0, 32'h80000000, o);
      go_idle(1);
      checks++; if (o.data !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned got %h want 00000080", o.data); end
      ref_data = 32'h00000080;
   endtask

   task automatic test_half_store();
      obs_t o;
      run_access(1'b0, 1'b1, 32'h202, 32'h1234ABCD, SZ_HALF, 1'b0, 0, 32'h77777777, o);
      go_idle(1);
      checks++; if (o.wdata !== 32'hABCDABCD) begin errors++; $display("FAIL half_store_wdata got %h want abcdabcd", o.wdata); end
      checks++; if (o.be !== 4'b1100 || o.addr !== 32'h200 || o.we !== 1'b1) begin errors++;
         $display("FAIL half_store_bus got be %b addr %h we %b want 1100 200 1", o.be, o.addr, o.we); end
      checks++; if (o.data !== ref_data) begin errors++; $display("FAIL half_store_data got %h want %h", o.data, ref_data); end
   endtask

   task automatic test_slow_memory();
      obs_t o, o2;
      // Ack in the fifth BUSY cycle: stall = request cycle + 5 BUSY cycles.
      run_access(1'b1, 1'b0, 32'h40C, 32'h0, SZ_WORD, 1'b0, 4, 32'hCAFEF00D, o);
      run_access(1'b1, 1'b0, 32'h410, 32'h0, SZ_WORD, 1'b0, 0, 32'h0BADF00D, o2);
      go_idle(1);
      checks++; if (!o.stable) begin errors++; $display("FAIL slow_stable got unstable bus want stable"); end
      checks++; if (o.stall_cyc != 6 || o.busy_cyc != 5) begin errors++;
         $display("FAIL slow_cycles got stall %0d busy %0d want 6 5", o.stall_cyc, o.busy_cyc); end
      checks++; if (o.data !== 32'hCAFEF00D) begin errors++; $display("FAIL slow_data got %h want cafef00d", o.data); end
      checks++; if (o2.first_stall !== 1'b1) begin errors++;
         $display("FAIL slow_done_len got first stall %b want 1", o2.first_stall); end
      ref_data = 32'h0BADF00D;
   endtask

   task automatic test_reset_busy();
      MemRead_ex_mm = 1'b1; MemWrite_ex_mm = 1'b0; y_ex_mm = 32'h300; size_ex_mm = SZ_WORD;
      Unsigned_ex_mm = 1'b0; bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_enter got req %b want 1", bus.mem_req); end
      reset = 1'b1; MemRead_ex_mm = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin errors++;
         $display("FAIL rst_busy_abandon got req %b stall %b want 0 0", bus.mem_req, stall); end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      checks++; if (data !== 32'h0 || bus.mem_req !== 1'b0) begin errors++;
         $display("FAIL rst_busy_late_ack got data %h req %b want 0 0", data, bus.mem_req); end
      @(posedge clk); #1;
      ref_data = 32'h0;
   endtask

   task automatic test_misalign();
      obs_t o;
      run_access(1'b1, 1'b0, 32'h101, 32'h0, SZ_WORD, 1'b0, 0, 32'h11223344, o);
      go_idle(2);
`ifdef MEM_MISALIGN_EXC_EN
      checks++; if (o.mis_cyc != 1 || o.busy_cyc != 0) begin errors++;
         $display("FAIL misalign_exc got pulses %0d req cycles %0d want 1 0", o.mis_cyc, o.busy_cyc); end
      checks++; if (o.data !== ref_data || o.stall_cyc != 1) begin errors++;
         $display("FAIL misalign_exc_data got %h stall %0d want %h 1", o.data, o.stall_cyc, ref_data); end
`else
      checks++; if (o.addr !== 32'h100 || o.be !== 4'b1111) begin errors++;
         $display("FAIL misalign_word got addr %h be %b want 100 1111", o.addr, o.be); end
      checks++; if (o.data !== 32'h11223344) begin errors++; $display("FAIL misalign_word_data got %h want 11223344", o.data); end
      ref_data = 32'h11223344;
`endif
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2, o3;
      run_access(1'b0, 1'b1, 32'h500, 32'hA1B2C3D4, SZ_BYTE, 1'b0, 1, 32'h0, o1);
      run_access(1'b1, 1'b1, 32'h504, 32'h99887766, SZ_WORD, 1'b0, 0, 32'h12345678, o2);
      run_access(1'b1, 1'b0, 32'h506, 32'h0, SZ_HALF, 1'b0, 2, 32'h8001FFFF, o3);
      go_idle(1);
      checks++; if (o1.wdata !== 32'hD4D4D4D4 || o1.be !== 4'b0001) begin errors++;
         $display("FAIL b2b_byte_store got wdata %h be %b want d4d4d4d4 0001", o1.wdata, o1.be); end
      checks++; if (o2.we !== 1'b1 || o2.data !== ref_data || o2.first_stall !== 1'b1) begin errors++;
         $display("FAIL b2b_both_is_store got we %b data %h first stall %b want 1 %h 1", o2.we, o2.data, o2.first_stall, ref_data); end
      checks++; if (o3.data !== 32'hFFFF8001 || o3.first_stall !== 1'b1) begin errors++;
         $display("FAIL b2b_half_load got data %h first stall %b want ffff8001 1", o3.data, o3.first_stall); end
      ref_data = 32'hFFFF8001;
   endtask

   task automatic test_random();
      obs_t o;
      for (int n = 0; n < 40; n++) begin
         int          kind  = int'($urandom_range(0, 2));
         logic        rd    = (kind != 1);
         logic        wr    = (kind != 0);
         logic [31:0] a     = $urandom;
         logic [31:0] wd    = $urandom;
         logic [31:0] rdat  = $urandom;
         logic [1:0]  sz    = 2'($urandom_range(0, 3));
         logic        uns   = 1'($urandom_range(0, 1));
         int          delay = int'($urandom_range(0, 3));
         logic [31:0] exp_data;
         run_access(rd, wr, a, wd, sz, uns, delay, rdat, o);
         if (n % 3 == 0) go_idle(1);
         checks++; if (!o.done) begin errors++; $display("FAIL rnd%0d_timeout got no DONE want DONE", n); end
         if (model_misaligned(a, sz)) begin
            checks++; if (o.busy_cyc != 0 || o.mis_cyc != 1 || o.data !== ref_data) begin errors++;
               $display("FAIL rnd%0d_misalign got req %0d pulses %0d data %h want 0 1 %h", n, o.busy_cyc, o.mis_cyc, o.data, ref_data); end
         end else begin
            exp_data = wr ? ref_data : model_load(rdat, a, sz, uns);
            checks++; if (o.stall_cyc != 2 + delay || o.busy_cyc != 1 + delay || !o.stable) begin errors++;
               $display("FAIL rnd%0d_timing got stall %0d busy %0d stable %b want %0d %0d 1", n, o.stall_cyc, o.busy_cyc, o.stable, 2 + delay, 1 + delay); end
            checks++; if (o.addr !== (a - 32'(a[1:0])) || o.be !== model_be(a, sz) || o.we !== wr) begin errors++;
               $display("FAIL rnd%0d_bus got addr %h be %b we %b want %h %b %b", n, o.addr, o.be, o.we, a - 32'(a[1:0]), model_be(a, sz), wr); end
            if (wr) begin
               checks++; if (o.wdata !== model_wdata(wd, sz)) begin errors++;
                  $display("FAIL rnd%0d_wdata got %h want %h", n, o.wdata, model_wdata(wd, sz)); end
            end
            checks++; if (o.data !== exp_data) begin errors++;
               $display("FAIL rnd%0d_data got %h want %h", n, o.data, exp_data); end
            ref_data = exp_data;
         end
      end
      go_idle(1);
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_slow_memory();
      test_reset_busy();
      test_misalign();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
